// File: rtl/apb_gpio_arb_if.sv
// Bundles the two requester ports, the shared response and the APB master
// signals of the GPIO arbiter. The master modport is the arbiter's view; the
// slave modport is the view of whatever sits around it (requesters + APB slave).
interface apb_gpio_arb_if #(
   parameter int AW = 32
);
   logic          req0_valid;
   logic          req0_write;
   logic [AW-1:0] req0_addr;
   logic [31:0]   req0_wdata;
   logic          req1_valid;
   logic          req1_write;
   logic [AW-1:0] req1_addr;
   logic [31:0]   req1_wdata;
   logic          req0_ack;
   logic          req1_ack;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [31:0]   PWDATA;
   logic [31:0]   PRDATA;
   logic          PREADY;

   modport master (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req0_ack, req1_ack, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req0_ack, req1_ack, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/apb_gpio_arb.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// One transfer at a time: IDLE (grant) -> SETUP -> ACCESS (wait states,
// optional timeout) -> DONE (ack pulse). Every output comes from a flop.
module apb_gpio_arb #(
   parameter int TIMEOUT_CYC = 16,
   parameter int AW          = 32
) (
   input logic            sys_clk,
   input logic            sys_rst,
   apb_gpio_arb_if.master bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Counter is wide enough to hold TIMEOUT_CYC; it sticks at all-ones.
   localparam int            CW      = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : {CW{1'b0}};
   localparam logic          TO_EN   = (TIMEOUT_CYC > 0) ? 1'b1 : 1'b0;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          grant_r, grant_s;           // 0 = req0 owns the transfer, 1 = req1
   logic          last_grant_r, last_grant_s;
   logic          pick_s;
   logic          psel_r, psel_s;
   logic          penable_r, penable_s;
   logic          pwrite_r, pwrite_s;
   logic [AW-1:0] paddr_r, paddr_s;
   logic [31:0]   pwdata_r, pwdata_s;
   logic          ack0_r, ack0_s;
   logic          ack1_r, ack1_s;
   logic [31:0]   rdata_r, rdata_s;
   logic          err_r, err_s;

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and next-output decode for the whole transfer sequence.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      grant_s      = grant_r;
      last_grant_s = last_grant_r;
      pick_s       = 1'b0;
      psel_s       = psel_r;
      penable_s    = penable_r;
      pwrite_s     = pwrite_r;
      paddr_s      = paddr_r;
      pwdata_s     = pwdata_r;
      ack0_s       = 1'b0;
      ack1_s       = 1'b0;
      rdata_s      = rdata_r;
      err_s        = err_r;
      case (state_r)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               // Tie goes to whoever was not granted last; a sole requester wins.
               if (bus.req0_valid && bus.req1_valid) begin
                  pick_s = ~last_grant_r;
               end else begin
                  pick_s = bus.req1_valid;
               end
               grant_s      = pick_s;
               last_grant_s = pick_s;
               pwrite_s     = pick_s ? bus.req1_write : bus.req0_write;
               paddr_s      = pick_s ? bus.req1_addr  : bus.req0_addr;
               pwdata_s     = pick_s ? bus.req1_wdata : bus.req0_wdata;
               psel_s       = 1'b1;
               penable_s    = 1'b0;
               cnt_s        = {CW{1'b0}};
               state_s      = SETUP;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            penable_s = 1'b1;
            state_s   = ACCESS;
         end
         ACCESS: begin
            if (bus.PREADY) begin
               // Normal completion beats a timeout landing on the same edge.
               state_s   = DONE;
               psel_s    = 1'b0;
               penable_s = 1'b0;
               rdata_s   = pwrite_r ? 32'h0000_0000 : bus.PRDATA;
               err_s     = 1'b0;
               ack0_s    = ~grant_r;
               ack1_s    = grant_r;
            end else begin
               if (cnt_r != CNT_MAX) begin
                  cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  cnt_s = cnt_r;
               end
               if (TO_EN && (cnt_r == TO_LAST)) begin
                  state_s   = DONE;
                  psel_s    = 1'b0;
                  penable_s = 1'b0;
                  rdata_s   = 32'h0000_0000;
                  err_s     = 1'b1;
                  ack0_s    = ~grant_r;
                  ack1_s    = grant_r;
               end else begin
                  state_s = ACCESS;
               end
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s   = IDLE;
            psel_s    = 1'b0;
            penable_s = 1'b0;
         end
      endcase
   end

   // Output, arbitration and wait-counter registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_r        <= {CW{1'b0}};
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         psel_r       <= 1'b0;
         penable_r    <= 1'b0;
         pwrite_r     <= 1'b0;
         paddr_r      <= {AW{1'b0}};
         pwdata_r     <= 32'h0000_0000;
         ack0_r       <= 1'b0;
         ack1_r       <= 1'b0;
         rdata_r      <= 32'h0000_0000;
         err_r        <= 1'b0;
      end else begin
         cnt_r        <= cnt_s;
         grant_r      <= grant_s;
         last_grant_r <= last_grant_s;
         psel_r       <= psel_s;
         penable_r    <= penable_s;
         pwrite_r     <= pwrite_s;
         paddr_r      <= paddr_s;
         pwdata_r     <= pwdata_s;
         ack0_r       <= ack0_s;
         ack1_r       <= ack1_s;
         rdata_r      <= rdata_s;
         err_r        <= err_s;
      end
   end

   assign bus.PSEL      = psel_r;
   assign bus.PENABLE   = penable_r;
   assign bus.PWRITE    = pwrite_r;
   assign bus.PADDR     = paddr_r;
   assign bus.PWDATA    = pwdata_r;
   assign bus.req0_ack  = ack0_r;
   assign bus.req1_ack  = ack1_r;
   assign bus.rsp_rdata = rdata_r;
   assign bus.rsp_err   = err_r;
endmodule

// File: tb/tb_apb_gpio_arb.sv
// Bench for apb_gpio_arb: directed and random rounds of requests, a small
// memory-backed APB slave with programmable wait states, a reference model
// that predicts service order and responses, and a negedge monitor that pops
// the expected queue on every ack.
module tb_apb_gpio_arb;
   localparam int TO = 16;

   typedef struct {
      bit          id;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          err;
      int          acc;
   } exp_t;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;

   apb_gpio_arb_if #(.AW(32)) bus ();

   apb_gpio_arb #(.TIMEOUT_CYC(TO), .AW(32)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus.master)
   );

   always #5 sys_clk = ~sys_clk;

   exp_t        sb_q[$];
   int          wait_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] slave_mem [8];
   logic [31:0] model_mem [8];
   bit          model_last;
   bit          r_w [2];
   logic [31:0] r_a [2];
   logic [31:0] r_d [2];
   int          r_wait [2];

   function automatic logic [31:0] mem_init(input int i);
      return (i == 0) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(i));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // APB slave: pops a wait count at SETUP, raises PREADY after that many ACCESS cycles.
   int s_w = 0;
   int s_k = 0;
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         bus.PREADY = 1'b0;
         bus.PRDATA = 32'h0;
         s_k = 0;
         for (int i = 0; i < 8; i++) slave_mem[i] = mem_init(i);
      end else if (bus.PSEL && !bus.PENABLE) begin
         if (wait_q.size() > 0) begin
            s_w = wait_q.pop_front();
         end else begin
            s_w = 0;
            total++;
            bad++;
            $display("FAIL slave_wait_q: got empty queue at SETUP, expected an entry");
         end
         s_k = 0;
         bus.PREADY = 1'b0;
         bus.PRDATA = $urandom;
      end else if (bus.PSEL && bus.PENABLE) begin
         if (s_k == s_w) begin
            bus.PREADY = 1'b1;
            if (bus.PWRITE) begin
               slave_mem[bus.PADDR[4:2]] = bus.PWDATA;
               bus.PRDATA = $urandom;
            end else begin
               bus.PRDATA = slave_mem[bus.PADDR[4:2]];
            end
         end else begin
            bus.PREADY = 1'b0;
            bus.PRDATA = $urandom;
         end
         s_k++;
      end else begin
         bus.PREADY = 1'b0;
         bus.PRDATA = $urandom;
      end
   end

   // Monitor: per-cycle protocol checks plus scoreboard pop on every ack.
   int          m_psel_cnt = 0;
   int          m_pen_cnt  = 0;
   bit          m_prev_ack = 1'b0;
   bit          m_prev_psel = 1'b0;
   logic [31:0] m_prev_addr, m_prev_wdata;
   logic        m_prev_wr;
   exp_t        m_e;
   always @(negedge sys_clk) begin
      if (sys_rst) begin
         m_psel_cnt  = 0;
         m_pen_cnt   = 0;
         m_prev_ack  = 1'b0;
         m_prev_psel = 1'b0;
      end else begin
         if (bus.PSEL)    m_psel_cnt++;
         if (bus.PENABLE) m_pen_cnt++;
         check("penable_implies_psel", 32'(!bus.PENABLE || bus.PSEL), 32'd1);
         check("acks_onehot", 32'(bus.req0_ack && bus.req1_ack), 32'd0);
         if (m_prev_psel) begin
            check("paddr_stable",  bus.PADDR,  m_prev_addr);
            check("pwdata_stable", bus.PWDATA, m_prev_wdata);
            check("pwrite_stable", 32'(bus.PWRITE), 32'(m_prev_wr));
         end
         if (m_prev_ack) check("no_grant_in_done", 32'(bus.PSEL), 32'd0);
         if (bus.PSEL && !bus.PENABLE) begin
            if (sb_q.size() > 0) begin
               check("setup_paddr",  bus.PADDR,  sb_q[0].addr);
               check("setup_pwdata", bus.PWDATA, sb_q[0].wdata);
               check("setup_pwrite", 32'(bus.PWRITE), 32'(sb_q[0].wr));
            end else begin
               total++;
               bad++;
               $display("FAIL unexpected_grant: got SETUP at addr %h, expected no transfer", bus.PADDR);
            end
         end
         if (bus.req0_ack || bus.req1_ack) begin
            if (sb_q.size() > 0) begin
               m_e = sb_q.pop_front();
               check("ack_id",     32'(bus.req1_ack), 32'(m_e.id));
               check("rsp_rdata",  bus.rsp_rdata, m_e.rdata);
               check("rsp_err",    32'(bus.rsp_err), 32'(m_e.err));
               check("psel_cycles",    32'(m_psel_cnt), 32'(m_e.acc + 1));
               check("penable_cycles", 32'(m_pen_cnt),  32'(m_e.acc));
            end else begin
               total++;
               bad++;
               $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d, expected none", bus.req0_ack, bus.req1_ack);
            end
            m_psel_cnt = 0;
            m_pen_cnt  = 0;
         end
         m_prev_ack   = bus.req0_ack || bus.req1_ack;
         m_prev_psel  = bus.PSEL;
         m_prev_addr  = bus.PADDR;
         m_prev_wdata = bus.PWDATA;
         m_prev_wr    = bus.PWRITE;
      end
   end

   task automatic model_reinit();
      for (int i = 0; i < 8; i++) model_mem[i] = mem_init(i);
      model_last = 1'b1;
   endtask

   task automatic set_req(input int id, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int w);
      r_w[id] = wr;
      r_a[id] = a;
      r_d[id] = d;
      r_wait[id] = w;
   endtask

   // Predict one transfer of requester id and queue it for slave and monitor.
   task automatic serve_exp(input int id);
      exp_t e;
      int   w;
      w       = r_wait[id];
      e.id    = id[0];
      e.wr    = r_w[id];
      e.addr  = r_a[id];
      e.wdata = r_d[id];
      e.err   = (w >= TO);
      e.acc   = e.err ? TO : (w + 1);
      if (e.err) begin
         e.rdata = 32'h0;
      end else if (e.wr) begin
         e.rdata = 32'h0;
         model_mem[r_a[id][4:2]] = r_d[id];
      end else begin
         e.rdata = model_mem[r_a[id][4:2]];
      end
      sb_q.push_back(e);
      wait_q.push_back(w);
   endtask

   task automatic drive(input int id);
      if (id == 0) begin
         bus.req0_valid = 1'b1; bus.req0_write = r_w[0];
         bus.req0_addr  = r_a[0]; bus.req0_wdata = r_d[0];
      end else begin
         bus.req1_valid = 1'b1; bus.req1_write = r_w[1];
         bus.req1_addr  = r_a[1]; bus.req1_wdata = r_d[1];
      end
   endtask

   // One round: raise the chosen requests together, hold each until its ack.
   task automatic run_round(input bit v0, input bit v1, input bit drop);
      bit d0, d1;
      int n;
      if (v0 && v1) begin
         if (model_last) begin
            serve_exp(0); serve_exp(1);
         end else begin
            serve_exp(1); serve_exp(0);
         end
      end else if (v0) begin
         serve_exp(0); model_last = 1'b0;
      end else begin
         serve_exp(1); model_last = 1'b1;
      end
      if (v0) drive(0);
      if (v1) drive(1);
      d0 = !v0;
      d1 = !v1;
      n  = 0;
      while (!(d0 && d1) && n < 300) begin
         @(negedge sys_clk);
         n++;
         if (bus.req0_ack) begin bus.req0_valid = 1'b0; d0 = 1'b1; end
         if (bus.req1_ack) begin bus.req1_valid = 1'b0; d1 = 1'b1; end
         if (drop && bus.PSEL && !bus.PENABLE) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
         end
      end
      if (!(d0 && d1)) begin
         total++;
         bad++;
         $display("FAIL round_timeout: got acks done0=%0d done1=%0d, expected both done", d0, d1);
         bus.req0_valid = 1'b0;
         bus.req1_valid = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  pat, r, w;
      bit  drop;
      bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = 32'h0; bus.req0_wdata = 32'h0;
      bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = 32'h0; bus.req1_wdata = 32'h0;
      model_reinit();
      #1 sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("rst_psel",    32'(bus.PSEL), 32'd0);
      check("rst_penable", 32'(bus.PENABLE), 32'd0);
      check("rst_pwrite",  32'(bus.PWRITE), 32'd0);
      check("rst_paddr",   bus.PADDR, 32'h0);
      check("rst_pwdata",  bus.PWDATA, 32'h0);
      check("rst_acks",    32'({bus.req0_ack, bus.req1_ack}), 32'd0);
      check("rst_rdata",   bus.rsp_rdata, 32'h0);
      check("rst_err",     32'(bus.rsp_err), 32'd0);
      sys_rst = 1'b0;

      // Single write, no wait states.
      set_req(0, 1'b1, 32'h04, 32'hA5A5_0001, 0);
      run_round(1'b1, 1'b0, 1'b0);
      // Read with three wait states.
      set_req(1, 1'b0, 32'h00, 32'h0, 3);
      run_round(1'b0, 1'b1, 1'b0);
      // Ties alternate.
      set_req(0, 1'b0, 32'h04, 32'h1111_0000, 0);
      set_req(1, 1'b1, 32'h08, 32'h2222_0000, 1);
      run_round(1'b1, 1'b1, 1'b0);
      set_req(0, 1'b1, 32'h0C, 32'h3333_0000, 2);
      set_req(1, 1'b0, 32'h0C, 32'h4444_0000, 0);
      run_round(1'b1, 1'b1, 1'b0);
      // Timeout boundary: 15 waits completes, 16 times out.
      set_req(0, 1'b0, 32'h08, 32'h0, 15);
      run_round(1'b1, 1'b0, 1'b0);
      set_req(1, 1'b0, 32'h00, 32'h0, 16);
      run_round(1'b0, 1'b1, 1'b0);
      set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 20);
      run_round(1'b1, 1'b0, 1'b0);
      // Requester drops valid after grant; transfer still acks.
      set_req(1, 1'b1, 32'h14, 32'h5555_AAAA, 2);
      run_round(1'b0, 1'b1, 1'b1);

      // Reset during ACCESS aborts the read without an ack.
      @(negedge sys_clk);
      set_req(0, 1'b0, 32'h08, 32'h0, 5);
      begin
         exp_t e;
         e.id = 1'b0; e.wr = 1'b0; e.addr = 32'h08; e.wdata = 32'h0;
         e.rdata = 32'h0; e.err = 1'b0; e.acc = 0;
         sb_q.push_back(e);
         wait_q.push_back(5);
      end
      drive(0);
      r = 0;
      while (!(bus.PSEL && bus.PENABLE) && r < 50) begin
         @(negedge sys_clk);
         r++;
      end
      check("reached_access", 32'(bus.PSEL && bus.PENABLE), 32'd1);
      sys_rst = 1'b1;
      #1;
      check("async_rst_psel",    32'(bus.PSEL), 32'd0);
      check("async_rst_penable", 32'(bus.PENABLE), 32'd0);
      check("async_rst_ack0",    32'(bus.req0_ack), 32'd0);
      sb_q.delete();
      wait_q.delete();
      model_reinit();
      repeat (2) @(negedge sys_clk);
      r_wait[0] = 1;
      sys_rst = 1'b0;
      run_round(1'b1, 1'b0, 1'b0);
      // First tie after the re-grant of req0 goes to req1.
      set_req(0, 1'b1, 32'h18, 32'h6666_0000, 0);
      set_req(1, 1'b0, 32'h18, 32'h0, 0);
      run_round(1'b1, 1'b1, 1'b0);

      // Random rounds.
      for (int k = 0; k < 40; k++) begin
         pat = $urandom_range(1, 3);
         for (int id = 0; id < 2; id++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       w = $urandom_range(0, 3);
            else if (r == 7) w = 15;
            else if (r == 8) w = 16;
            else             w = $urandom_range(17, 20);
            set_req(id, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom, w);
         end
         drop = (pat != 3) && ($urandom_range(0, 3) == 0);
         run_round(pat[0], pat[1], drop);
      end

      repeat (4) @(negedge sys_clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      check("wait_q_empty",     32'(wait_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/apb_gpio_arb.md
APB_GPIO_ARB -- requirements
Module: apb_gpio_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, max ACCESS cycles waited for PREADY; 0 disables timeout.
REQ-002 Parameter: AW, default 32, address width of PADDR and req*_addr.
REQ-003 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-004 sys_rst  in  1  asynchronous, active-high reset.
REQ-005 req0_valid, req1_valid  in  1 each  requester holds high with stable fields until its ack.
REQ-006 req0_write, req1_write  in  1 each  1 = write, 0 = read.
REQ-007 req0_addr, req1_addr  in  AW each  transfer address.
REQ-008 req0_wdata, req1_wdata  in  32 each  write data.
REQ-009 req0_ack, req1_ack  out  1 each  one-cycle completion pulse.
REQ-010 rsp_rdata  out  32  read data, valid while either ack is high.
REQ-011 rsp_err  out  1  timeout flag, valid while either ack is high.
REQ-012 PSEL, PENABLE, PWRITE  out  1 each  APB master control to the GPIO APB slave.
REQ-013 PADDR  out  AW; PWDATA  out  32  APB master address and write data.
REQ-014 PRDATA  in  32; PREADY  in  1  APB slave response.

Function
- REQ-015 FSM states IDLE, SETUP, ACCESS, DONE. All outputs SHALL be registered.
- REQ-016 IDLE: if any req*_valid is high, the block SHALL grant one requester, latch its write/addr/wdata into PWRITE/PADDR/PWDATA, and go to SETUP. Otherwise it SHALL stay in IDLE.
- REQ-017 Arbitration SHALL be round-robin:
  - A sole requester wins.
  - When both request in the same cycle, the requester not granted last wins.
  - last_grant SHALL update on every grant.
- REQ-018 SETUP: PSEL=1, PENABLE=0, for exactly one cycle; then go to ACCESS.
- REQ-019 ACCESS: PSEL=1, PENABLE=1. Address, control and write data SHALL stay stable until leaving ACCESS.
- REQ-020 ACCESS with PREADY=1 sampled on an edge:
  - go to DONE;
  - capture PRDATA into rsp_rdata for a read, or 0 for a write;
  - rsp_err=0.
- REQ-021 Wait-state counter:
  - Counts ACCESS cycles with PREADY=0.
  - When it reaches TIMEOUT_CYC (TIMEOUT_CYC>0), go to DONE with rsp_err=1 and rsp_rdata=0.
  - PREADY=1 on that same edge SHALL win (normal completion, rsp_err=0).
- REQ-022 DONE:
  - PSEL=0, PENABLE=0;
  - the granted requester's req*_ack=1 for exactly one cycle;
  - then go to IDLE.
  - No arbitration occurs in DONE.
- REQ-023 Minimum transfer SHALL be 4 cycles (IDLE grant, SETUP, ACCESS, DONE). Back-to-back grants SHALL start no earlier than the IDLE cycle after DONE.
- REQ-024 Only one req*_ack SHALL ever be high. rsp_rdata and rsp_err SHALL hold their value until the next DONE.
- REQ-025 A requester dropping valid mid-transfer is a protocol violation. The transfer SHALL still complete and ack SHALL still pulse.
- REQ-026 The wait-state counter SHALL saturate and not wrap. It SHALL clear on entry to SETUP.

Reset
- REQ-027 When sys_rst=1, the block SHALL immediately (asynchronously) force:
  - state=IDLE;
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0;
  - req0_ack, req1_ack, rsp_rdata, rsp_err = 0;
  - wait counter = 0;
  - last_grant=1, so req0 wins the first tie.
- REQ-028 Reset asserted mid-transfer SHALL abort it without an ack. After reset release, arbitration SHALL restart in IDLE on the next edge.

Verification
- REQ-029 Single write, PREADY tied 1: req0 write addr 0x04 data 0xA5A5_0001 -> PSEL high 2 cycles, PENABLE high 1 cycle, req0_ack pulse on the 4th cycle, rsp_err=0.
- REQ-030 Read with 3 wait states: req1 read addr 0x00, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles, req1_ack with rsp_rdata=0x1234_5678.
- REQ-031 Simultaneous requests after reset: both valid, both held -> req0 served first, then req1. Repeating gives req0 then req1 again, per round-robin alternation.
- REQ-032 Timeout: TIMEOUT_CYC=16, PREADY held 0 -> exactly 16 ACCESS cycles, then ack with rsp_err=1, rsp_rdata=0.
- REQ-033 Reset in ACCESS: assert sys_rst during ACCESS of a req0 read -> PSEL/PENABLE drop in the same cycle, no req0_ack. After release, a held req0 is re-granted normally.
- REQ-034 Check every cycle, assertion: PENABLE implies PSEL; PADDR/PWRITE/PWDATA stable from SETUP to DONE; never both acks high.
